// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch/jump type encodings and fetch reset/exception vectors.
package cpu_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_J    = 3'b011,
    BR_JAL  = 3'b100,
    BR_JR   = 3'b101,
    BR_JALR = 3'b110,
    BR_RSVD = 3'b111
  } br_type_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;

endpackage

// File: rtl/npc_target_gen.sv
// D-stage target generator: computes the branch, jump and register targets plus the taken flag.
module npc_target_gen (
  input  logic [2:0]  i_br_type,
  input  logic        i_eq,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_instr_index,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_pc_d,
  output logic        o_taken,
  output logic        o_is_jump,
  output logic        o_is_reg,
  output logic [31:0] o_br_target,
  output logic [31:0] o_j_target,
  output logic [31:0] o_r_target
);
  import cpu_pkg::*;

  assign o_br_target = i_pc_d + 32'd4 + {{14{i_imm16[15]}}, i_imm16, 2'b00};
  assign o_j_target  = {i_pc_d[31:28], i_instr_index, 2'b00};
  assign o_r_target  = i_rs_data;

  always_comb begin
    o_taken   = 1'b0;
    o_is_jump = 1'b0;
    o_is_reg  = 1'b0;
    case (br_type_e'(i_br_type))
      BR_BEQ:         o_taken = i_eq;
      BR_BNE:         o_taken = !i_eq;
      BR_J, BR_JAL:   begin o_taken = 1'b1; o_is_jump = 1'b1; end
      BR_JR, BR_JALR: begin o_taken = 1'b1; o_is_reg  = 1'b1; end
      default:        o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_redirect.sv
// Fetch PC register and next-PC select with delay-slot semantics and zero-bubble redirect.
// Optional misaligned jr/jalr trap to EXC_PC is enabled by defining ALIGN_CHECK_EN.
module npc_redirect #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [31:0] EXC_PC   = cpu_pkg::EXC_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        eq_i,
  input  logic [2:0]  br_type,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_data,
  output logic [31:0] pc_f,
  output logic [31:0] pc_d,
  output logic        redirect,
  output logic [31:0] link_addr,
  output logic        addr_err
);

  logic [31:0] r_pc_f, r_pc_d;
  logic        w_taken, w_is_jump, w_is_reg;
  logic [31:0] w_br_target, w_j_target, w_r_target, w_npc;

  npc_target_gen u_tgt (
    .i_br_type    (br_type),
    .i_eq         (eq_i),
    .i_imm16      (imm16),
    .i_instr_index(instr_index),
    .i_rs_data    (rs_data),
    .i_pc_d       (r_pc_d),
    .o_taken      (w_taken),
    .o_is_jump    (w_is_jump),
    .o_is_reg     (w_is_reg),
    .o_br_target  (w_br_target),
    .o_j_target   (w_j_target),
    .o_r_target   (w_r_target)
  );

`ifdef ALIGN_CHECK_EN
  logic w_misalign;
  logic r_addr_err;

  always_comb begin
    w_misalign = 1'b0;
    w_npc      = r_pc_f + 32'd4;
    if (w_taken) begin
      if (w_is_reg) begin
        if (w_r_target[1:0] != 2'b00) begin
          w_npc      = EXC_PC;
          w_misalign = 1'b1;
        end else begin
          w_npc = w_r_target;
        end
      end else if (w_is_jump) begin
        w_npc = w_j_target;
      end else begin
        w_npc = w_br_target;
      end
    end
  end

  // A stalled edge never loads EXC_PC, so the flag drops there too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_addr_err <= 1'b0;
    else             r_addr_err <= w_misalign && !stall;
  end

  assign addr_err = r_addr_err;
`else
  logic w_unused;

  always_comb begin
    w_npc = r_pc_f + 32'd4;
    if (w_taken) begin
      if (w_is_reg)       w_npc = {w_r_target[31:2], 2'b00};
      else if (w_is_jump) w_npc = w_j_target;
      else                w_npc = w_br_target;
    end
  end

  assign w_unused = ^{EXC_PC, w_r_target[1:0]};
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_f <= RESET_PC;
      r_pc_d <= RESET_PC - 32'd4;
    end else if (!stall) begin
      r_pc_f <= w_npc;
      r_pc_d <= r_pc_f;
    end
  end

  assign pc_f      = r_pc_f;
  assign pc_d      = r_pc_d;
  assign redirect  = w_taken && !stall;
  assign link_addr = r_pc_d + 32'd8;

endmodule

// File: doc/npc_redirect.md
Name: npc_redirect

Overview:
- Fetch-side PC register and next-PC unit for the 5-stage pipelined CPU.
- Consumes the D-stage equality flag from the branch comparator, together with the decoded branch/jump type and operands, and redirects fetch accordingly.
- Holds the F-stage PC and the D-stage PC, honours pipeline stalls, and implements MIPS delay-slot semantics: the instruction after a branch always executes.

Parameters:
- RESET_PC, 32'h0000_3000, value loaded into pc_f on reset.
- EXC_PC, 32'h0000_4180, redirect target on a misaligned jump (only when ALIGN_CHECK_EN is defined).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  from the hazard unit; freezes pc_f and pc_d.
- eq_i  in  1  D-stage comparator result (1 = operands equal).
- br_type  in  3  D-stage control:
  - 000 none, 001 beq, 010 bne, 011 j, 100 jal, 101 jr, 110 jalr, 111 reserved (treated as none).
- imm16  in  16  D-stage branch offset (signed, in words).
- instr_index  in  26  D-stage j/jal target field.
- rs_data  in  32  D-stage forwarded rs value (jr/jalr target).
- pc_f  out  32  current fetch address.
- pc_d  out  32  PC of the instruction in D.
- redirect  out  1  combinational; 1 when the next pc_f is not pc_f+4.
- link_addr  out  32  pc_d+8, used as the jal/jalr write-back value.
- addr_err  out  1  misaligned-target flag (constant 0 when the feature is off).

Behaviour:
- Reset (asynchronous, active-high):
  - pc_f = RESET_PC.
  - pc_d = RESET_PC - 4, so link_addr = RESET_PC + 4.
  - addr_err = 0.
- Taken condition (combinational, from D-stage inputs):
  - beq: eq_i = 1.
  - bne: eq_i = 0.
  - j, jal, jr, jalr: always taken.
  - none/reserved: never taken.
- Branch target: pc_d + 4 + (sign-extended imm16 << 2), 32-bit wrap-around.
- Jump target: {pc_d[31:28], instr_index, 2'b00}.
- Register target: rs_data.
- npc = taken ? target : pc_f + 4. The delay slot is already at pc_f and is never flushed.
- redirect = taken && !stall.
- On each rising edge with stall = 0: pc_f <= npc, pc_d <= pc_f.
- On each rising edge with stall = 1: pc_f and pc_d hold.
  - The branch stays in D and is re-evaluated with updated eq_i/rs_data on the next unstalled cycle.
  - A decision seen during a stall never takes effect.
- Latency: a D-stage branch decision changes pc_f one cycle later (zero-bubble redirect).
- link_addr is combinational from pc_d and is valid regardless of br_type.
- pc_f + 4 wraps from 32'hFFFF_FFFC to 32'h0000_0000; no error is raised.
- Reset asserted mid-redirect wins over everything; all state returns to reset values immediately.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- When defined:
  - A taken jr/jalr with rs_data[1:0] != 0 sets npc = EXC_PC.
  - addr_err is registered high for exactly one cycle, on the edge that loads EXC_PC.
  - Branch and j/jal targets are always aligned and are not checked.
- When undefined:
  - rs_data is used with bits [1:0] forced to 00.
  - addr_err is tied to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - br_type encodings (BR_NONE, BR_BEQ, BR_BNE, BR_J, BR_JAL, BR_JR, BR_JALR).
  - RESET_PC and EXC_PC constants.
- One natural sub-module: npc_target_gen. It is purely combinational, computes the three targets plus the taken flag, and the top level owns the registers.

Test Plan:
- Reset then release, stall = 0, br_type = none for 3 cycles -> pc_f = 3000, 3004, 3008, 300C; redirect = 0.
- D at pc_d = 3004, beq, eq_i = 1, imm16 = 16'h0003 -> next pc_f = 3014; redirect = 1 in that cycle.
- Same, but bne with eq_i = 1 -> pc_f = pc_f_prev + 4; redirect = 0.
- jal at pc_d = 3008, instr_index = 26'h0000C40 -> pc_f = 0000_3100; link_addr = 3010 while jal is in D.
- beq taken with stall = 1 for 2 cycles, then 0 -> pc_f/pc_d frozen for 2 edges; target loaded on the first unstalled edge only.
- ALIGN_CHECK_EN: jr with rs_data = 3002 -> pc_f = 4180, addr_err = 1 for one cycle. Without the macro -> pc_f = 3000, addr_err = 0.
